// File: rtl/bg_scene_controller.sv
// Frame-synchronous sequencer for the VGA background layer: scroll offset, scene select, brightness.
// Define BG_SCENE_FADE_EN for the fade-out / swap / fade-in sequence; otherwise a scene change swaps in one frame.
module bg_scene_controller #(
  parameter int WORLD_WIDTH = 1280,
  parameter int SCROLL_STEP = 2,
  parameter int FADE_FRAMES = 4,
  parameter int NUM_SCENES  = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        moveRight,
  input  logic        moveLeft,
  input  logic        freeze,
  input  logic        sceneNext,
  output logic [10:0] bgOffsetX,
  output logic [1:0]  sceneSel,
  output logic [2:0]  brightness,
  output logic        busy,
  output logic        sceneDone
);

  localparam int               CNT_W       = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FADE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [11:0]      WIDTH_W     = 12'(WORLD_WIDTH);
  localparam logic [11:0]      STEP_W      = 12'(SCROLL_STEP);
  localparam logic [1:0]       SCENE_LAST  = 2'(NUM_SCENES - 1);
  localparam logic [2:0]       BRIGHT_FULL = 3'd7;

  typedef enum logic [1:0] {
    S_NORMAL   = 2'd0,
    S_FADE_OUT = 2'd1,
    S_SWAP     = 2'd2,
    S_FADE_IN  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             pending_q;
  logic [10:0]      offset_q;
  logic [10:0]      offset_d;
  logic [1:0]       scene_q;
  logic [1:0]       scene_d;
  logic [2:0]       bright_q;
  logic             busy_q;
  logic             done_q;

  logic [11:0]      offset_ext;
  logic [11:0]      right_sum;
  logic             scroll_right;
  logic             scroll_left;
  logic             accept;

  // Scroll candidate for this frame; 12-bit arithmetic keeps the wrap compare free of overflow.
  always_comb begin
    offset_ext   = {1'b0, offset_q};
    right_sum    = offset_ext + STEP_W;
    scroll_right = !freeze && moveRight && !moveLeft;
    scroll_left  = !freeze && moveLeft && !moveRight;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    offset_d     = offset_q;
    if (scroll_right) begin
      offset_d = (right_sum >= WIDTH_W) ? 11'(right_sum - WIDTH_W) : right_sum[10:0];
    end else if (scroll_left) begin
      offset_d = (offset_ext < STEP_W) ? 11'(offset_ext + WIDTH_W - STEP_W)
                                       : 11'(offset_ext - STEP_W);
    end
  end

  assign scene_d = (scene_q == SCENE_LAST) ? 2'd0 : scene_q + 2'd1;
  assign accept  = sceneNext || pending_q;

  // NOTE: all state here is plain flops with an async reset; there is no memory array to leave unreset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_NORMAL;
      frame_cnt_q <= '0;
      pending_q   <= 1'b0;
      offset_q    <= '0;
      scene_q     <= '0;
      bright_q    <= BRIGHT_FULL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; later assignments in this block win, which the
      // accept path relies on to override the pending capture and the sceneDone clear.
      done_q <= 1'b0;
      if (state_q == S_NORMAL && sceneNext) begin
        pending_q <= 1'b1;
      end

      if (startOfFrame) begin
        unique case (state_q)
          S_NORMAL: begin
            if (accept) begin
              pending_q   <= 1'b0;
              frame_cnt_q <= '0;
              busy_q      <= 1'b1;
`ifdef BG_SCENE_FADE_EN
              state_q     <= S_FADE_OUT;
`else
              state_q     <= S_SWAP;
`endif
            end else begin
              offset_q <= offset_d;
            end
          end

          S_FADE_OUT: begin
            if (frame_cnt_q == CNT_LAST) begin
              frame_cnt_q <= '0;
              bright_q    <= bright_q - 3'd1;
              if (bright_q == 3'd1) begin
                state_q <= S_SWAP;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + CNT_ONE;
            end
          end

          S_SWAP: begin
            scene_q     <= scene_d;
            offset_q    <= '0;
            frame_cnt_q <= '0;
`ifdef BG_SCENE_FADE_EN
            state_q     <= S_FADE_IN;
`else
            state_q     <= S_NORMAL;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
`endif
          end

          S_FADE_IN: begin
            if (frame_cnt_q == CNT_LAST) begin
              frame_cnt_q <= '0;
              bright_q    <= bright_q + 3'd1;
              if (bright_q == BRIGHT_FULL - 3'd1) begin
                state_q <= S_NORMAL;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              frame_cnt_q <= frame_cnt_q + CNT_ONE;
            end
          end

          default: state_q <= S_NORMAL;
        endcase
      end
    end
  end

  assign bgOffsetX  = offset_q;
  assign sceneSel   = scene_q;
  assign brightness = bright_q;
  assign busy       = busy_q;
  assign sceneDone  = done_q;

endmodule

// File: tb/tb_bg_scene_controller.sv
// Scoreboard bench for bg_scene_controller: stimulus pushes expected snapshots, a monitor pops and compares.
// Expected values follow the frame timing of either build (BG_SCENE_FADE_EN defined or not).
module tb_bg_scene_controller;

  localparam int WW   = 1280;
  localparam int STEP = 2;
  localparam int FF   = 4;
  localparam int NS   = 4;

`ifdef BG_SCENE_FADE_EN
  localparam int SWAP_K  = 7 * FF + 1;
  localparam int T_END   = 14 * FF + 1;
  localparam int ABORT_K = 40;
  localparam int EXTRA_K = 10;
`else
  localparam int SWAP_K  = 1;
  localparam int T_END   = 1;
  localparam int ABORT_K = 1;
  localparam int EXTRA_K = 1;
`endif

  typedef struct packed {
    logic [15:0] id;
    logic [10:0] off;
    logic [1:0]  sel;
    logic [2:0]  br;
    logic        busy;
    logic        done;
  } exp_t;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        moveRight;
  logic        moveLeft;
  logic        freeze;
  logic        sceneNext;
  logic [10:0] bgOffsetX;
  logic [1:0]  sceneSel;
  logic [2:0]  brightness;
  logic        busy;
  logic        sceneDone;

  logic        probe;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks    = 0;
  int          n_fail      = 0;
  int          done_pulses = 0;

  bg_scene_controller #(
    .WORLD_WIDTH(WW),
    .SCROLL_STEP(STEP),
    .FADE_FRAMES(FF),
    .NUM_SCENES (NS)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .startOfFrame(startOfFrame),
    .moveRight   (moveRight),
    .moveLeft    (moveLeft),
    .freeze      (freeze),
    .sceneNext   (sceneNext),
    .bgOffsetX   (bgOffsetX),
    .sceneSel    (sceneSel),
    .brightness  (brightness),
    .busy        (busy),
    .sceneDone   (sceneDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got %0d, expected %0d", name, id, act, expv);
    end
  endtask

  // Monitor: outputs of a probed cycle are compared 2 ns after its rising edge.
  always @(posedge clk) begin
    if (probe) begin
      #2;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        mon_e = exp_q.pop_front();
        check("bgOffsetX",  int'(mon_e.id), int'(bgOffsetX),  int'(mon_e.off));
        check("sceneSel",   int'(mon_e.id), int'(sceneSel),   int'(mon_e.sel));
        check("brightness", int'(mon_e.id), int'(brightness), int'(mon_e.br));
        check("busy",       int'(mon_e.id), int'(busy),       int'(mon_e.busy));
        check("sceneDone",  int'(mon_e.id), int'(sceneDone),  int'(mon_e.done));
      end
    end
  end

  always @(posedge clk) begin
    if (sceneDone === 1'b1) done_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input int id, input int off, input int sel, input int br,
                              input int bsy, input int dn);
    exp_t e;
    e.id   = 16'(id);
    e.off  = 11'(off);
    e.sel  = 2'(sel);
    e.br   = 3'(br);
    e.busy = 1'(bsy);
    e.done = 1'(dn);
    return e;
  endfunction

  // Expected snapshot after the k-th SOF counted from the accepting SOF (k = 0).
  function automatic exp_t trans_exp(input int id, input int k, input int sel0, input int off0);
    int sel1;
    int br;
    sel1 = (sel0 + 1) % NS;
`ifdef BG_SCENE_FADE_EN
    br = (k < SWAP_K) ? 7 - k / FF : (k - SWAP_K) / FF;
`else
    br = 7;
`endif
    if (k < SWAP_K) return mk(id, off0, sel0, br, 1, 0);
    return mk(id, 0, sel1, br, (k < T_END) ? 1 : 0, (k == T_END) ? 1 : 0);
  endfunction

  task automatic tick(input logic sof, input logic sn, input logic chk, input exp_t e);
    @(negedge clk);
    startOfFrame = sof;
    sceneNext    = sn;
    probe        = chk;
    if (chk) exp_q.push_back(e);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic frame(input logic sn, input exp_t e);
    tick(1'b1, sn, 1'b1, e);
    idle();
  endtask

  task automatic async_reset_check(input int id);
    @(negedge clk);
    #1 resetN = 1'b0;
    #1;
    check("async_rst bgOffsetX",  id, int'(bgOffsetX),  0);
    check("async_rst sceneSel",   id, int'(sceneSel),   0);
    check("async_rst brightness", id, int'(brightness), 7);
    check("async_rst busy",       id, int'(busy),       0);
    check("async_rst sceneDone",  id, int'(sceneDone),  0);
    moveRight = 1'b0;
    tick(1'b1, 1'b1, 1'b1, mk(id + 1, 0, 0, 7, 0, 0));
    idle();
    @(negedge clk);
    resetN = 1'b1;
    tick(1'b0, 1'b0, 1'b1, mk(id + 2, 0, 0, 7, 0, 0));
    idle();
    frame(1'b0, mk(id + 3, 0, 0, 7, 0, 0));
  endtask

  // One scene change with moveRight held so any scroll while busy shows up.
  task automatic run_transition(input int sel0, input int off0, input bit via_pending,
                                input bit abort, input int base_id);
    int sel1;
    sel1 = (sel0 + 1) % NS;
    moveRight = 1'b1;
    if (via_pending) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      idle();
      frame(1'b0, trans_exp(base_id, 0, sel0, off0));
    end else begin
      frame(1'b1, trans_exp(base_id, 0, sel0, off0));
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    idle();
    for (int k = 1; k <= T_END; k++) begin
      if (abort && k == ABORT_K) begin
        async_reset_check(base_id + 200);
        return;
      end
      if (k == T_END) begin
        tick(1'b1, (k == EXTRA_K) ? 1'b1 : 1'b0, 1'b1, trans_exp(base_id + k, k, sel0, off0));
        moveRight = 1'b0;
        tick(1'b0, 1'b0, 1'b1, mk(base_id + 100, 0, sel1, 7, 0, 0));
        idle();
      end else begin
        frame((k == EXTRA_K) ? 1'b1 : 1'b0, trans_exp(base_id + k, k, sel0, off0));
      end
    end
    frame(1'b0, mk(base_id + 101, 0, sel1, 7, 0, 0));
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    moveRight    = 1'b0;
    moveLeft     = 1'b0;
    freeze       = 1'b0;
    sceneNext    = 1'b0;
    probe        = 1'b0;

    tick(1'b0, 1'b0, 1'b1, mk(1, 0, 0, 7, 0, 0));
    idle();
    @(negedge clk);
    resetN = 1'b1;

    // No SOF: moveRight toggling must not move anything.
    moveRight = 1'b1; idle();
    moveRight = 1'b0; idle();
    moveRight = 1'b1;
    tick(1'b0, 1'b0, 1'b1, mk(2, 0, 0, 7, 0, 0));
    idle();

    for (int i = 1; i <= 10; i++) frame(1'b0, mk(100 + i, 2 * i, 0, 7, 0, 0));
    moveRight = 1'b0; moveLeft = 1'b1;
    for (int i = 1; i <= 10; i++) frame(1'b0, mk(120 + i, 20 - 2 * i, 0, 7, 0, 0));
    frame(1'b0, mk(131, 1278, 0, 7, 0, 0));
    moveLeft = 1'b0; moveRight = 1'b1;
    frame(1'b0, mk(132, 0, 0, 7, 0, 0));
    frame(1'b0, mk(133, 2, 0, 7, 0, 0));

    moveLeft = 1'b1;
    for (int i = 0; i < 5; i++) frame(1'b0, mk(140 + i, 2, 0, 7, 0, 0));
    moveLeft = 1'b0; freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      moveRight = (i % 2 == 0);
      moveLeft  = (i % 2 == 1);
      frame(1'b0, mk(150 + i, 2, 0, 7, 0, 0));
    end
    freeze = 1'b0; moveRight = 1'b0; moveLeft = 1'b0;

    run_transition(0, 2, 1'b0, 1'b0, 1000);
    run_transition(1, 0, 1'b1, 1'b0, 2000);
    run_transition(2, 0, 1'b1, 1'b0, 3000);
    run_transition(3, 0, 1'b0, 1'b0, 4000);
    run_transition(0, 0, 1'b1, 1'b1, 5000);

    repeat (4) idle();
    @(posedge clk);
    #5;
    check("scoreboard_drained", 9000, exp_q.size(), 0);
    check("sceneDone_pulses",   9001, done_pulses,  4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
